mdsa_frame_host: RTL

- Host-side controller for the MDSA sorter frame interface; it drives start/en/data_in and consumes rdy/output_enable/data_out.
- Packs an element stream into one frame, launches a sort, waits for completion, captures the result, then streams the sorted elements back out.
- Sits between the system stream fabric and the MDSA sorter core; it is the initiator that the sorter responds to.

---
 rtl/mdsa_frame_host.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/mdsa_frame_host.sv
// Host-side frame controller for the MDSA sorter: packs a stream into one frame, kicks a sort,
// captures the result and streams it back. Optional order checker: MDSA_HOST_ORDER_CHECK_EN.
module mdsa_frame_host #(
  parameter int ELEM_W         = 8,
  parameter int NUM_ELEM       = 256,
  parameter int TIMEOUT_CYCLES = 4096,
  localparam int FRAME_W       = ELEM_W * NUM_ELEM
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [ELEM_W-1:0]  s_data,
  input  logic               s_last,
  output logic               start,
  output logic               en,
  output logic [FRAME_W-1:0] data_in,
  input  logic               rdy,
  input  logic               output_enable,
  input  logic [FRAME_W-1:0] data_out,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [ELEM_W-1:0]  m_data,
  output logic               m_last,
  output logic               busy,
  output logic               timeout_err,
  output logic               order_err
);

  localparam int IDX_W = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEM - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {ST_LOAD, ST_KICK, ST_WAIT, ST_DRAIN} state_t;

  state_t            state_reg;
  logic [IDX_W-1:0]  idx_reg;
  logic [CNT_W-1:0]  wait_cnt_reg;
  logic [ELEM_W-1:0] in_mem  [NUM_ELEM];
  logic [ELEM_W-1:0] out_mem [NUM_ELEM];
  logic [ELEM_W-1:0] out_word[NUM_ELEM];

  logic             load_beat;
  logic             frame_end;
  logic             capture;
  logic             drain_beat;
  logic [IDX_W-1:0] idx_inc;

  assign load_beat  = (state_reg == ST_LOAD) && s_valid && s_ready;
  assign frame_end  = load_beat && (s_last || (idx_reg == LAST_IDX));
  assign capture    = (state_reg == ST_WAIT) && rdy && output_enable;
  assign drain_beat = (state_reg == ST_DRAIN) && m_valid && m_ready;
  assign idx_inc    = idx_reg + 1'b1;

  // Element k of a frame lives at bits [k*ELEM_W +: ELEM_W], element 0 in the LSBs.
  for (genvar gi = 0; gi < NUM_ELEM; gi++) begin : g_pack
    assign data_in[gi*ELEM_W +: ELEM_W] = in_mem[gi];
    assign out_word[gi] = data_out[gi*ELEM_W +: ELEM_W];
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      out_mem <= out_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_LOAD;
      idx_reg      <= '0;
      wait_cnt_reg <= '0;
      s_ready      <= 1'b1;
      start        <= 1'b0;
      en           <= 1'b0;
      m_valid      <= 1'b0;
      m_data       <= '0;
      m_last       <= 1'b0;
      busy         <= 1'b0;
      timeout_err  <= 1'b0;
      for (int k = 0; k < NUM_ELEM; k++) begin
        in_mem[k] <= '0;
      end
    end else begin
      start       <= 1'b0;
      timeout_err <= 1'b0;
      case (state_reg)
        ST_LOAD: begin
          if (load_beat) begin
            in_mem[idx_reg] <= s_data;
            busy            <= 1'b1;
            if (frame_end) begin
              // Unused tail slots are all-ones so they sort to the end.
              for (int k = 0; k < NUM_ELEM; k++) begin
                if (k > int'(idx_reg)) begin
                  in_mem[k] <= '1;
                end
              end
              state_reg <= ST_KICK;
              idx_reg   <= '0;
              s_ready   <= 1'b0;
              start     <= 1'b1;
              en        <= 1'b1;
            end else begin
              idx_reg <= idx_inc;
            end
          end
        end
        ST_KICK: begin
          state_reg    <= ST_WAIT;
          wait_cnt_reg <= '0;
        end
        ST_WAIT: begin
          if (capture) begin
            state_reg <= ST_DRAIN;
            en        <= 1'b0;
            idx_reg   <= '0;
            m_valid   <= 1'b1;
            m_data    <= out_word[0];
            m_last    <= (LAST_IDX == '0);
          end else if (wait_cnt_reg == CNT_LAST) begin
            state_reg   <= ST_LOAD;
            en          <= 1'b0;
            s_ready     <= 1'b1;
            busy        <= 1'b0;
            timeout_err <= 1'b1;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (drain_beat) begin
            if (idx_reg == LAST_IDX) begin
              state_reg <= ST_LOAD;
              idx_reg   <= '0;
              m_valid   <= 1'b0;
              m_last    <= 1'b0;
              s_ready   <= 1'b1;
              busy      <= 1'b0;
            end else begin
              idx_reg <= idx_inc;
              m_data  <= out_mem[idx_inc];
              m_last  <= (idx_inc == LAST_IDX);
            end
          end
        end
        default: state_reg <= ST_LOAD;
      endcase
    end
  end

`ifdef MDSA_HOST_ORDER_CHECK_EN
  logic              order_err_reg;
  logic [ELEM_W-1:0] prev_reg;

  // idx_reg != 0 means an earlier element of this frame has already been accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      order_err_reg <= 1'b0;
      prev_reg      <= '0;
    end else if (drain_beat) begin
      prev_reg <= m_data;
      if ((idx_reg != '0) && (m_data < prev_reg)) begin
        order_err_reg <= 1'b1;
      end
    end
  end

  assign order_err = order_err_reg;
`else
  assign order_err = 1'b0;
`endif

endmodule
